byteswap_swap_stage: RTL and testbench
======================================

# byteswap_swap_stage

Streaming compute stage between the AXI read master and the AXI write master inside the byteswap vswap datapath. Accepts a run of C_DATA_WIDTH-bit read beats, reverses the byte order of every C_WORD_BIT_WIDTH-bit word in each beat, and forwards the result with tlast on the final beat. Counts beats against the transfer size latched at start and pulses done once the last beat is accepted downstream.

## Interface
- C_DATA_WIDTH, 512, stream beat width in bits; multiple of C_WORD_BIT_WIDTH.
- C_WORD_BIT_WIDTH, 32, swap granule in bits; multiple of 8.
- C_XFER_SIZE_WIDTH, 32, width of the byte-count control input.

- aclk  in  1  clock; the block uses one clock.
- areset  in  1  reset; synchronous, active-high.
- ctrl_start  in  1  single-cycle start pulse.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes in the run; sampled only on ctrl_start.
- ctrl_done  out  1  single-cycle done pulse.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  C_DATA_WIDTH  input beat from the read master.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output beat ready from the write master.
- m_axis_tdata  out  C_DATA_WIDTH  byte-swapped beat.
- m_axis_tlast  out  1  marks the final beat of the run.

## Operation
- Beat count: beats = ceil(bytes / (C_DATA_WIDTH/8)).
  - Compute in C_XFER_SIZE_WIDTH+1 bits so the add cannot overflow at the maximum byte count.
  - A partial final beat is still a full beat and is swapped in full.
- Swap: within each word, output byte j = input byte (C_WORD_BIT_WIDTH/8-1-j). All words are independent.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN: on ctrl_start with beats ≠ 0. Load the input and output counters.
  - IDLE -> DONE: on ctrl_start with beats = 0.
  - RUN -> DRAIN: on the edge that accepts the last input beat.
  - DRAIN -> DONE: on the edge where m_axis accepts the tlast beat. If that beat is accepted on the same edge it is loaded, go RUN -> DONE directly.
  - DONE -> IDLE: unconditionally after one cycle. ctrl_done = 1 only in DONE.
- s_axis_tready is 0 in IDLE, DRAIN and DONE. Input beats beyond the count are never accepted.
- ctrl_start outside IDLE is ignored.
- m_axis_tlast = 1 exactly when the output counter indicates the final beat and m_axis_tvalid = 1.
- m_axis_tvalid and m_axis_tdata hold stable while m_axis_tready = 0 (AXI-Stream rule).
- areset at any point returns the FSM to IDLE and discards buffered beats. No done pulse follows.

## Timing
- Values after reset: s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, ctrl_done 0, m_axis_tdata 0.
- Latency: a beat accepted on edge k is presented on m_axis from the cycle after edge k. No combinational path from s_axis_tdata to m_axis_tdata.
- Throughput: one beat per cycle when both sides stream continuously.
- ctrl_done asserts on the cycle after the edge that accepts the tlast beat. For a zero-byte run, it asserts on the cycle after ctrl_start.
- s_axis_tready may assert on the cycle after ctrl_start.

## Configuration
- BYTESWAP_SWAP_STAGE_SKID_EN defined:
  - Two-entry output register plus skid slot.
  - s_axis_tready comes directly from a flop.
  - No combinational path from m_axis_tready to s_axis_tready.
  - Full throughput is kept across single-cycle downstream stalls.
- Undefined:
  - Single output register.
  - s_axis_tready = in RUN and (!m_axis_tvalid or m_axis_tready), which is a combinational path.
  - Same latency and same data results.

## Structure
- Shared package byteswap_pkg holds:
  - the FSM state typedef (IDLE/RUN/DRAIN/DONE);
  - localparam BYTES_PER_BEAT = C_DATA_WIDTH/8 and its log2;
  - function beats_from_bytes.
- One natural sub-module: byteswap_axis_skid. It is the register slice used in the SKID_EN build and also reused in the write path.

## Test plan
- Word 0x11223344 in every lane, bytes = 64, m_axis_tready held 1:
  - one output beat, every word 0x44332211, tlast = 1;
  - ctrl_done one cycle after acceptance.
- bytes = 16384, both sides streaming:
  - 256 beats, tlast only on beat 256;
  - one beat per cycle, data matches the reference swap model.
- bytes = 100 (partial beat) → 2 beats accepted; a third offered input beat sees s_axis_tready = 0.
- bytes = 0 → no m_axis_tvalid; ctrl_done on the cycle after ctrl_start.
- Random m_axis_tready (50%), 64 beats:
  - m_axis_tdata stable under stall, no lost or duplicated beats;
  - in SKID_EN builds, s_axis_tready is registered.
- areset mid-run after 10 of 32 beats:
  - outputs take their reset values, no ctrl_done pulse;
  - a following run of bytes = 128 completes correctly.

Source files
------------

// File: rtl/byteswap_pkg.sv
// Shared types and helpers for the byteswap vswap datapath: FSM state encoding,
// default beat geometry and the byte-count to beat-count conversion.
package byteswap_pkg;

    localparam int C_DATA_WIDTH_DEF      = 512;
    localparam int C_WORD_BIT_WIDTH_DEF  = 32;
    localparam int C_XFER_SIZE_WIDTH_DEF = 32;

    localparam int BYTES_PER_BEAT      = C_DATA_WIDTH_DEF / 8;
    localparam int BYTES_PER_BEAT_LOG2 = $clog2(BYTES_PER_BEAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } swap_state_e;

    // Rounds up to whole beats; 64-bit arithmetic keeps the add from wrapping
    // at the largest byte count of any realistic control width.
    function automatic logic [63:0] beats_from_bytes(input logic [63:0] num_bytes,
                                                     input int unsigned beat_log2);
        logic [63:0] round_up;
        round_up = (64'd1 << beat_log2) - 64'd1;
        return (num_bytes + round_up) >> beat_log2;
    endfunction

endpackage

// File: rtl/byteswap_axis_skid.sv
// AXI-Stream register slice. SKID=1 gives a registered s_ready backed by a skid
// slot; SKID=0 gives a single output register with pass-through ready.
import byteswap_pkg::*;

module byteswap_axis_skid #(
    parameter int W    = 512,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         m_valid_q, m_valid_d;
    logic [W-1:0] m_data_q,  m_data_d;
    logic         s_fire;

    assign s_fire  = s_valid && s_ready;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    generate
        if (SKID) begin : g_skid
            logic         sk_valid_q, sk_valid_d;
            logic [W-1:0] sk_data_q,  sk_data_d;

            // Ready depends only on the skid flop, never on m_ready.
            assign s_ready = !sk_valid_q;

            always_comb begin
                m_valid_d  = m_valid_q;
                m_data_d   = m_data_q;
                sk_valid_d = sk_valid_q;
                sk_data_d  = sk_data_q;
                if (m_valid_q && !m_ready) begin
                    if (s_fire) begin
                        sk_valid_d = 1'b1;
                        sk_data_d  = s_data;
                    end
                end else if (sk_valid_q) begin
                    m_valid_d  = 1'b1;
                    m_data_d   = sk_data_q;
                    sk_valid_d = 1'b0;
                end else begin
                    m_valid_d = s_fire;
                    if (s_fire) begin
                        m_data_d = s_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    sk_valid_q <= 1'b0;
                    sk_data_q  <= '0;
                end else begin
                    sk_valid_q <= sk_valid_d;
                    sk_data_q  <= sk_data_d;
                end
            end
        end else begin : g_single
            assign s_ready = !m_valid_q || m_ready;

            always_comb begin
                m_valid_d = m_valid_q;
                m_data_d  = m_data_q;
                if (s_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: rtl/byteswap_swap_stage.sv
// Byte-reversing stream stage between the AXI read and write masters.
// Define BYTESWAP_SWAP_STAGE_SKID_EN for a registered s_axis_tready via a skid slice.
import byteswap_pkg::*;

module byteswap_swap_stage #(
    parameter int C_DATA_WIDTH      = C_DATA_WIDTH_DEF,
    parameter int C_WORD_BIT_WIDTH  = C_WORD_BIT_WIDTH_DEF,
    parameter int C_XFER_SIZE_WIDTH = C_XFER_SIZE_WIDTH_DEF
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         ctrl_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                         m_axis_tlast
);

    localparam int          CW         = C_XFER_SIZE_WIDTH + 1;
    localparam int          WORD_BYTES = C_WORD_BIT_WIDTH / 8;
    localparam int          NUM_WORDS  = C_DATA_WIDTH / C_WORD_BIT_WIDTH;
    localparam int unsigned BEAT_LOG2  = $clog2(C_DATA_WIDTH / 8);

`ifdef BYTESWAP_SWAP_STAGE_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    swap_state_e             state_q, state_d;
    logic [CW-1:0]           in_cnt_q, in_cnt_d;
    logic [CW-1:0]           out_cnt_q, out_cnt_d;
    logic [CW-1:0]           start_beats;
    logic [C_DATA_WIDTH-1:0] swapped;
    logic                    run, slice_ready, s_fire, m_fire, out_last;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            for (genvar gj = 0; gj < WORD_BYTES; gj++) begin : g_byte
                assign swapped[gi*C_WORD_BIT_WIDTH + gj*8 +: 8] =
                    s_axis_tdata[gi*C_WORD_BIT_WIDTH + (WORD_BYTES-1-gj)*8 +: 8];
            end
        end
    endgenerate

    assign start_beats = CW'(beats_from_bytes(64'(ctrl_xfer_size_in_bytes), BEAT_LOG2));
    assign run         = (state_q == RUN);
    assign s_fire      = s_axis_tvalid && s_axis_tready;
    assign m_fire      = m_axis_tvalid && m_axis_tready;
    assign out_last    = (out_cnt_q == CW'(1));

    assign s_axis_tready = run && slice_ready;
    assign m_axis_tlast  = m_axis_tvalid && out_last;
    assign ctrl_done     = (state_q == DONE);

    // The slice only sees valid while running, so it can never take a beat past the count.
    byteswap_axis_skid #(
        .W    (C_DATA_WIDTH),
        .SKID (SKID_EN)
    ) u_out_slice (
        .clk     (aclk),
        .srst    (areset),
        .s_valid (s_axis_tvalid && run),
        .s_ready (slice_ready),
        .s_data  (swapped),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (m_axis_tdata)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (s_fire) begin
            in_cnt_d = in_cnt_q - CW'(1);
        end
        if (m_fire) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    in_cnt_d  = start_beats;
                    out_cnt_d = start_beats;
                    state_d   = (start_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (m_fire && out_last) begin
                    state_d = DONE;
                end else if (s_fire && in_cnt_q == CW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_fire && out_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_byteswap_swap_stage.sv
// Randomized scoreboard bench for byteswap_swap_stage: a driver pushes expected
// swapped beats, an independent monitor pops and compares on every m_axis handshake.
module tb_byteswap_swap_stage;

    typedef struct {
        logic [511:0] data;
        bit           last;
    } exp_beat_t;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic         ctrl_start = 1'b0;
    logic [31:0]  ctrl_xfer_size_in_bytes = '0;
    logic         ctrl_done;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [511:0] s_tdata = '0;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [511:0] m_tdata;
    logic         m_tlast;

    int        n_checks = 0;
    int        n_fail = 0;
    exp_beat_t expq[$];
    int        neg_cyc = 0;
    int        done_due = -1;
    int        done_count = 0;
    bit        zero_flag = 1'b0;
    int        ready_mode = 0;

    always #5 clk = ~clk;

    byteswap_swap_stage dut (
        .aclk                    (clk),
        .areset                  (areset),
        .ctrl_start              (ctrl_start),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .s_axis_tvalid           (s_tvalid),
        .s_axis_tready           (s_tready),
        .s_axis_tdata            (s_tdata),
        .m_axis_tvalid           (m_tvalid),
        .m_axis_tready           (m_tready),
        .m_axis_tdata            (m_tdata),
        .m_axis_tlast            (m_tlast)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each 32-bit word has its 4 bytes listed in reverse order.
    function automatic logic [511:0] swap_ref(input logic [511:0] d);
        byte unsigned b_in[64];
        logic [511:0] r;
        for (int i = 0; i < 64; i++) b_in[i] = d[i*8 +: 8];
        for (int w = 0; w < 16; w++)
            for (int j = 0; j < 4; j++)
                r[(w*4 + j)*8 +: 8] = b_in[w*4 + 3 - j];
        return r;
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_ctrl_done"}, ctrl_done, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
    endtask

    // Downstream ready generator; in skid builds also probes that s_tready
    // does not react to m_tready within a cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(1));
`ifdef BYTESWAP_SWAP_STAGE_SKID_EN
            if (ready_mode == 1 && !areset) begin
                logic r0, r1;
                @(negedge clk);
                #2;
                r0 = s_tready;
                m_tready = !m_tready;
                #1;
                r1 = s_tready;
                m_tready = !m_tready;
                check("s_tready_registered", r1, r0);
            end
`endif
        end
    end

    // Monitor / scoreboard
    initial begin
        bit           prev_stall = 0;
        logic [511:0] prev_data = '0;
        exp_beat_t    e;
        forever begin
            @(negedge clk);
            neg_cyc++;
            if (areset) begin
                prev_stall = 0;
            end else begin
                if (ctrl_start && zero_flag) done_due = neg_cyc + 1;
                if (prev_stall) begin
                    check("hold_valid", m_tvalid, 1);
                    check("hold_data", m_tdata, prev_data);
                end
                if (!m_tvalid) begin
                    check("tlast_without_valid", m_tlast, 0);
                end else if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tvalid=1 with data %0h, required no beat", m_tdata);
                end else begin
                    e = expq[0];
                    check("tlast", m_tlast, e.last);
                    if (m_tready) begin
                        void'(expq.pop_front());
                        check("tdata", m_tdata, e.data);
                        if (e.last) done_due = neg_cyc + 1;
                    end
                end
                if (ctrl_done || neg_cyc == done_due)
                    check("done_timing", ctrl_done, neg_cyc == done_due);
                if (ctrl_done) done_count++;
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
            end
        end
    end

    // One transfer: start, offer beats with random gaps, probe past-count ready,
    // then wait for done. reset_after >= 0 aborts the run with areset instead.
    task automatic run_xfer(input int bytes, input int gap_pct, input bit fixed, input int reset_after);
        int beats, acc, budget, first_acc, last_acc, done_before;
        bit have_beat;
        exp_beat_t e;
        beats = (bytes + 63) / 64;
        acc = 0;
        budget = 0;
        first_acc = -1;
        last_acc = -1;
        have_beat = 0;
        done_before = done_count;
        @(posedge clk);
        #1;
        ctrl_xfer_size_in_bytes = 32'(bytes);
        ctrl_start = 1'b1;
        zero_flag = (beats == 0);
        @(posedge clk);
        #1;
        ctrl_start = 1'b0;
        zero_flag = 1'b0;
        while (acc < beats) begin
            if (reset_after >= 0 && acc == reset_after) begin
                areset = 1'b1;
                s_tvalid = 1'b0;
                expq.delete();
                done_due = -1;
                @(posedge clk);
                @(negedge clk);
                check_reset_outputs("midrun_reset");
                @(posedge clk);
                #1;
                areset = 1'b0;
                repeat (5) @(negedge clk);
                check("no_done_after_reset", done_count, done_before);
                $display("xfer bytes=%0d aborted by reset after %0d beats", bytes, acc);
                return;
            end
            if (!have_beat) begin
                s_tdata = fixed ? {16{32'h11223344}} : rand_beat();
                have_beat = 1;
            end
            s_tvalid = ($urandom_range(99) >= gap_pct);
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                e.data = fixed ? {16{32'h44332211}} : swap_ref(s_tdata);
                e.last = (acc == beats - 1);
                expq.push_back(e);
                if (first_acc < 0) first_acc = neg_cyc;
                last_acc = neg_cyc;
                acc++;
                have_beat = 0;
            end
            @(posedge clk);
            #1;
            budget++;
            if (budget > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL input_timeout: got %0d beats accepted, required %0d", acc, beats);
                break;
            end
        end
        s_tvalid = 1'b1;
        s_tdata = rand_beat();
        repeat (3) begin
            @(negedge clk);
            check("s_tready_past_count", s_tready, 0);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (gap_pct == 0 && ready_mode == 0 && beats > 1)
            check("throughput_cycles", last_acc - first_acc, beats - 1);
        budget = 0;
        while (done_count == done_before && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("done_seen", done_count - done_before, 1);
        check("queue_empty", expq.size(), 0);
        $display("xfer bytes=%0d beats=%0d accepted=%0d done=%0d", bytes, beats, acc, done_count - done_before);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge clk);

        ready_mode = 0;
        run_xfer(64, 0, 1'b1, -1);
        run_xfer(16384, 0, 1'b0, -1);
        run_xfer(100, 0, 1'b0, -1);
        run_xfer(0, 0, 1'b0, -1);
        ready_mode = 1;
        run_xfer(4096, 30, 1'b0, -1);
        ready_mode = 0;
        run_xfer(2048, 0, 1'b0, 10);
        run_xfer(128, 20, 1'b0, -1);

        repeat (10) @(negedge clk);
        check("final_queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
